// File: rtl/rx_frame_receiver.sv
// rx_frame_receiver
//
// Recovers frames from the sender's serial line, checks the frame alignment
// signal (F6 28) and the CRC-8 over the payload, and buffers the payload.
// Only a good frame is streamed out to the consumer. After the last byte is
// accepted, the block pulses an ACK back toward the sender.
//
// Optional feature macro: RX_CRC_CHECK_EN
//   defined   : a CRC mismatch drops the frame and pulses o_crc_err.
//   undefined : no CRC comparison is made and o_crc_err stays 0. Every frame
//               with a good FAS is drained and acknowledged.
//
// Ports
//   i_clk          single clock for the block
//   i_rst_n        asynchronous, active-low reset
//   i_otn_rx_data  serial line; idles high; asynchronous to i_clk
//   o_otn_tx_ack   high for ACK_CLKS cycles per accepted frame
//   o_pyld_data    payload byte
//   o_pyld_valid   o_pyld_data is valid
//   i_pyld_ready   consumer accepts the byte
//   o_crc_val      CRC of the last frame whose FAS matched
//   o_crc_err      one-cycle pulse on CRC mismatch
//   o_fas_err      one-cycle pulse on FAS mismatch
//   o_dbg_state    current FSM state, for observation only
//
// Handshake: a byte moves on every cycle where o_pyld_valid and i_pyld_ready
// are both high. o_pyld_valid and o_pyld_data are registered. Once valid
// rises, both stay unchanged until the byte is accepted.

module rx_frame_receiver #(
    parameter int PYLD_BYTES   = 16,
    parameter int CLKS_PER_BIT = 8,
    parameter int ACK_CLKS     = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_otn_rx_data,
    output logic       o_otn_tx_ack,
    output logic [7:0] o_pyld_data,
    output logic       o_pyld_valid,
    input  logic       i_pyld_ready,
    output logic [7:0] o_crc_val,
    output logic       o_crc_err,
    output logic       o_fas_err,
    output logic [2:0] o_dbg_state
);

    localparam int TOTAL_BITS = 8 * (PYLD_BYTES + 3);
    localparam int BIT_W      = $clog2(TOTAL_BITS);
    localparam int IDX_W      = $clog2(PYLD_BYTES + 1);
    localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam int ADDR_W     = (PYLD_BYTES > 1) ? $clog2(PYLD_BYTES) : 1;
    localparam int ACK_W      = (ACK_CLKS > 1) ? $clog2(ACK_CLKS) : 1;

    // The bit counter counts down, so each boundary below is the bit_cnt
    // value at the last bit of a given byte.
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(TOTAL_BITS - 1);
    localparam logic [BIT_W-1:0]  FAS0_END  = BIT_W'(8 * (PYLD_BYTES + 2));
    localparam logic [BIT_W-1:0]  FAS1_END  = BIT_W'(8 * (PYLD_BYTES + 1));
    localparam logic [BIT_W-1:0]  PAY_LO    = BIT_W'(8);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_CLKS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PYLD_BYTES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RECV  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;

    logic [2:0]        state;
    logic              rx_s1, rx_s2, rx_s3;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [ACK_W-1:0]  ack_cnt;
    logic [6:0]        byte_sr;
    logic [7:0]        crc_reg;
    logic              fas_ok;
`ifdef RX_CRC_CHECK_EN
    logic [7:0]        rx_crc;
`endif
    logic [7:0]        pyld_buf [PYLD_BYTES];

    logic       fall_edge;
    logic [7:0] new_byte;
    logic       crc_fb;
    logic [7:0] crc_next;
    logic       in_payload;
    logic       sample_now;

    assign o_dbg_state = state;
    assign fall_edge   = rx_s3 & ~rx_s2;
    assign new_byte    = {byte_sr, rx_s2};
    // Bit-serial CRC-8, polynomial x^8+x^2+x+1, MSB first.
    assign crc_fb      = crc_reg[7] ^ rx_s2;
    assign crc_next    = {crc_reg[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    assign in_payload  = (bit_cnt >= PAY_LO) && (bit_cnt < FAS1_END);
    assign sample_now  = (state == S_RECV) && (baud_cnt == '0);

    // The synchronizer and history flop reset to the idle line level. This
    // keeps reset release from looking like a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= i_otn_rx_data;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Payload storage holds no control state, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (sample_now && in_payload && (bit_cnt[2:0] == 3'd0))
            pyld_buf[wr_idx[ADDR_W-1:0]] <= new_byte;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            wr_idx       <= '0;
            rd_idx       <= '0;
            ack_cnt      <= '0;
            byte_sr      <= '0;
            crc_reg      <= '0;
            fas_ok       <= 1'b0;
`ifdef RX_CRC_CHECK_EN
            rx_crc       <= '0;
`endif
            o_otn_tx_ack <= 1'b0;
            o_pyld_data  <= '0;
            o_pyld_valid <= 1'b0;
            o_crc_val    <= '0;
            o_crc_err    <= 1'b0;
            o_fas_err    <= 1'b0;
        end else begin
            o_crc_err <= 1'b0;
            o_fas_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fall_edge) begin
                        baud_cnt <= BAUD_HALF;
                        bit_cnt  <= BIT_LAST;
                        wr_idx   <= '0;
                        crc_reg  <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    // Check again at mid start bit. A high line here means
                    // the edge was a glitch, so the frame is dropped silently.
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_FULL;
                        state    <= rx_s2 ? S_IDLE : S_RECV;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                S_RECV: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_FULL;
                        byte_sr  <= new_byte[6:0];
                        if (in_payload)
                            crc_reg <= crc_next;
                        if (bit_cnt == FAS0_END)
                            fas_ok <= (new_byte == 8'hF6);
                        if (bit_cnt == FAS1_END)
                            fas_ok <= fas_ok & (new_byte == 8'h28);
                        if (in_payload && (bit_cnt[2:0] == 3'd0))
                            wr_idx <= wr_idx + IDX_W'(1);
                        if (bit_cnt == '0) begin
`ifdef RX_CRC_CHECK_EN
                            rx_crc <= new_byte;
`endif
                            state  <= S_CHECK;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                S_CHECK: begin
                    if (!fas_ok) begin
                        o_fas_err <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        o_crc_val <= crc_reg;
`ifdef RX_CRC_CHECK_EN
                        if (crc_reg != rx_crc) begin
                            o_crc_err <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            o_pyld_valid <= 1'b1;
                            o_pyld_data  <= pyld_buf[0];
                            rd_idx       <= IDX_W'(1);
                            state        <= S_DRAIN;
                        end
`else
                        o_pyld_valid <= 1'b1;
                        o_pyld_data  <= pyld_buf[0];
                        rd_idx       <= IDX_W'(1);
                        state        <= S_DRAIN;
`endif
                    end
                end
                S_DRAIN: begin
                    // rd_idx always points at the next byte to present. When it
                    // equals LAST_IDX, the byte on the output is the last one.
                    if (i_pyld_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            o_pyld_valid <= 1'b0;
                            o_otn_tx_ack <= 1'b1;
                            ack_cnt      <= ACK_LAST;
                            state        <= S_ACK;
                        end else begin
                            o_pyld_data <= pyld_buf[rd_idx[ADDR_W-1:0]];
                            rd_idx      <= rd_idx + IDX_W'(1);
                        end
                    end
                end
                S_ACK: begin
                    if (ack_cnt == '0) begin
                        o_otn_tx_ack <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt - ACK_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_receiver.sv
// Testbench for rx_frame_receiver with PYLD_BYTES=4, CLKS_PER_BIT=4 and
// ACK_CLKS=16. A frame-level reference model works out the outcome of each
// frame: delivered bytes, ACK length, error pulses and displayed CRC.

module tb_rx_frame_receiver;

    localparam int PB  = 4;
    localparam int CPB = 4;
    localparam int AKC = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ready = 1'b1;
    logic       ack;
    logic [7:0] pdata;
    logic       pvalid;
    logic [7:0] crc_val;
    logic       crc_err;
    logic       fas_err;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    rx_frame_receiver #(
        .PYLD_BYTES  (PB),
        .CLKS_PER_BIT(CPB),
        .ACK_CLKS    (AKC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_otn_rx_data(rx),
        .o_otn_tx_ack (ack),
        .o_pyld_data  (pdata),
        .o_pyld_valid (pvalid),
        .i_pyld_ready (ready),
        .o_crc_val    (crc_val),
        .o_crc_err    (crc_err),
        .o_fas_err    (fas_err),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- scoreboard / counters ----------------
    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] pay [PB];
    logic [7:0] model_crc_val = 8'h00;

    int cyc = 0;
    int ack_cycles, crc_err_cnt, fas_err_cnt, valid_cycles;
    int first_acc, last_acc, ack_first;
    int rdy_mode = 0;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference CRC-8 (poly 0x07, init 0, no reflection, no final xor).
    function automatic logic [7:0] crc8_of_pay();
        logic [7:0] c = 8'h00;
        for (int b = 0; b < PB; b++) begin
            c = c ^ pay[b];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        ack_cycles   = 0;
        crc_err_cnt  = 0;
        fas_err_cnt  = 0;
        valid_cycles = 0;
        first_acc    = -1;
        last_acc     = -1;
        ack_first    = -1;
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", {31'd0, pvalid}, 32'd1);
                chk("hold_data", {24'd0, pdata}, {24'd0, prev_data});
            end
            if (pvalid) valid_cycles++;
            if (pvalid && ready) begin
                got_q.push_back(pdata);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (ack) begin
                if (ack_cycles == 0) begin
                    ack_first = cyc;
                    chk("bytes_before_ack", 32'(got_q.size()), 32'(PB));
                    chk("valid_low_at_ack", {31'd0, pvalid}, 32'd0);
                end
                ack_cycles++;
            end
            if (crc_err) crc_err_cnt++;
            if (fas_err) fas_err_cnt++;
            prev_valid = pvalid;
            prev_ready = ready;
            prev_data  = pdata;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- ready driver ----------------
    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: ready = 1'b1;
                1: ready = ((k % 4) == 0) || ((k % 4) == 3);
                2: ready = 1'($urandom_range(0, 1));
                default: ready = 1'b0;
            endcase
            k++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            rx = b[i];
            tick(CPB);
        end
    endtask

    task automatic send_start();
        rx = 1'b0;
        tick(CPB);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},     {31'd0, ack}, 32'd0);
        chk({tag, "_valid"},   {31'd0, pvalid}, 32'd0);
        chk({tag, "_data"},    {24'd0, pdata}, 32'd0);
        chk({tag, "_crc_val"}, {24'd0, crc_val}, 32'd0);
        chk({tag, "_crc_err"}, {31'd0, crc_err}, 32'd0);
        chk({tag, "_fas_err"}, {31'd0, fas_err}, 32'd0);
    endtask

    // Sends one frame built from pay[], applies the model and checks the result.
    task automatic run_frame(input string tag, input logic [7:0] f0,
                             input logic [7:0] f1, input logic [7:0] crc_xor);
        logic [7:0] crc_calc;
        bit fas_good, good, done;
        int exp_ack, exp_crc_err, exp_fas_err;

        crc_calc = crc8_of_pay();
        fas_good = (f0 == 8'hF6) && (f1 == 8'h28);
`ifdef RX_CRC_CHECK_EN
        good = fas_good && (crc_xor == 8'h00);
`else
        good = fas_good;
`endif
        if (fas_good) model_crc_val = crc_calc;
        exp_q.delete();
        if (good)
            for (int b = 0; b < PB; b++) exp_q.push_back(pay[b]);
        exp_ack     = good ? AKC : 0;
        exp_fas_err = fas_good ? 0 : 1;
        exp_crc_err = (fas_good && !good) ? 1 : 0;

        clear_mon();
        send_start();
        send_byte(f0);
        send_byte(f1);
        for (int b = 0; b < PB; b++) send_byte(pay[b]);
        send_byte(crc_calc ^ crc_xor);
        rx = 1'b1;

        done = 1'b0;
        for (int i = 0; i < 800 && !done; i++) begin
            tick(1);
            if (good) done = (ack_cycles > 0) && !ack;
            else      done = (i >= 40);
        end
        chk({tag, "_finished"}, {31'd0, done}, 32'd1);

        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_byte"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        chk({tag, "_ack_len"}, 32'(ack_cycles), 32'(exp_ack));
        chk({tag, "_crc_err"}, 32'(crc_err_cnt), 32'(exp_crc_err));
        chk({tag, "_fas_err"}, 32'(fas_err_cnt), 32'(exp_fas_err));
        chk({tag, "_crc_val"}, {24'd0, crc_val}, {24'd0, model_crc_val});
        if (good) begin
            chk({tag, "_ack_after_last"}, 32'(ack_first), 32'(last_acc + 1));
            if (rdy_mode == 0)
                chk({tag, "_back_to_back"}, 32'(last_acc - first_acc), 32'(PB - 1));
        end else begin
            chk({tag, "_no_valid"}, 32'(valid_cycles), 32'd0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit seen;
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(3);

        // Good frame from the plan
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        rdy_mode = 0;
        run_frame("good", 8'hF6, 8'h28, 8'h00);
        chk("good_crc_e3", {24'd0, crc_val}, 32'hE3);

        // Bad CRC (E2 instead of E3)
        run_frame("badcrc", 8'hF6, 8'h28, 8'h01);

        // FAS error
        run_frame("fas", 8'hF7, 8'h28, 8'h00);

        // Backpressure 1,0,0,1,...
        rdy_mode = 1;
        run_frame("bp", 8'hF6, 8'h28, 8'h00);
        rdy_mode = 0;

        // One-cycle glitch on the idle line
        clear_mon();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        chk("glitch_nbytes", 32'(got_q.size()), 32'd0);
        chk("glitch_valid", 32'(valid_cycles), 32'd0);
        chk("glitch_ack", 32'(ack_cycles), 32'd0);
        chk("glitch_errs", 32'(crc_err_cnt + fas_err_cnt), 32'd0);

        // Reset asserted mid-RECV
        pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'h3C; pay[3] = 8'hC3;
        send_start();
        send_byte(8'hF6);
        send_byte(8'h28);
        rst_n = 1'b0;
        #1;
        model_crc_val = 8'h00;
        check_reset_outputs("rst_recv");
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        run_frame("after_rst", 8'hF6, 8'h28, 8'h00);

        // Reset asserted mid-drain while the consumer stalls
        rdy_mode = 3;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        send_start();
        send_byte(8'hF6);
        send_byte(8'h28);
        for (int b = 0; b < PB; b++) send_byte(pay[b]);
        send_byte(crc8_of_pay());
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick(1);
            seen = pvalid;
        end
        chk("drain_valid_up", {31'd0, seen}, 32'd1);
        tick(3);
        chk("drain_held_byte0", {24'd0, pdata}, {24'd0, pay[0]});
        rst_n = 1'b0;
        #1;
        model_crc_val = 8'h00;
        check_reset_outputs("rst_drain");
        tick(3);
        rst_n = 1'b1;
        rdy_mode = 0;
        tick(3);

        // Randomized frames
        for (int n = 0; n < 8; n++) begin
            int kind;
            logic [7:0] f0, f1, cx;
            for (int b = 0; b < PB; b++) pay[b] = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 3);
            f0 = 8'hF6; f1 = 8'h28; cx = 8'h00;
            if (kind == 1) cx = 8'($urandom_range(1, 255));
            if (kind == 2) f0 = 8'hF6 ^ 8'($urandom_range(1, 255));
            if (kind == 3) f1 = 8'h28 ^ 8'($urandom_range(1, 255));
            rdy_mode = $urandom_range(0, 2);
            run_frame("rand", f0, f1, cx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
